// File: rtl/multicycle_control_fsm_if.sv
//------------------------------------------------------------------------------
// Module  : multicycle_control_fsm_if
// Brief   : Memory handshake and datapath control bundle for the multicycle FSM.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface multicycle_control_fsm_if #(
  parameter int INS_WIDTH = 32,
  parameter int ALU_WIDTH = 5,
  parameter int CNT_WIDTH = 16
);
  logic [INS_WIDTH-1:0] ins;
  logic                 mem_ready;
  logic                 mem_req;
  logic                 IorD;
  logic                 memWrite;
  logic                 IRWrite;
  logic                 PCWrite;
  logic                 branchEnable;
  logic [1:0]           PCSrc;
  logic                 ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic [ALU_WIDTH-1:0] ALUControl;
  logic                 regDst;
  logic                 regWriteEnable;
  logic                 memToReg;
  logic [2:0]           state;
  logic                 fault;
  logic [CNT_WIDTH-1:0] retired;

  modport slave (
    input  ins, mem_ready,
    output mem_req, IorD, memWrite, IRWrite, PCWrite, branchEnable, PCSrc,
           ALUSrcA, ALUSrcB, ALUControl, regDst, regWriteEnable, memToReg,
           state, fault, retired
  );

  modport master (
    output ins, mem_ready,
    input  mem_req, IorD, memWrite, IRWrite, PCWrite, branchEnable, PCSrc,
           ALUSrcA, ALUSrcB, ALUControl, regDst, regWriteEnable, memToReg,
           state, fault, retired
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
//------------------------------------------------------------------------------
// Module  : multicycle_control_fsm
// Brief   : FETCH/DECODE/EXEC/MEM/WB sequencer with memory timeout and retire count.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_control_fsm #(
  parameter int INS_WIDTH = 32,
  parameter int ALU_WIDTH = 5,
  parameter int TIMEOUT   = 16,
  parameter int CNT_WIDTH = 16
) (
  input  wire logic              clock,
  input  wire logic              reset_n,
  multicycle_control_fsm_if.slave bus
);

  localparam logic [2:0] c_FETCH  = 3'd0;
  localparam logic [2:0] c_DECODE = 3'd1;
  localparam logic [2:0] c_EXEC   = 3'd2;
  localparam logic [2:0] c_MEM    = 3'd3;
  localparam logic [2:0] c_WB     = 3'd4;
  localparam logic [2:0] c_FAULT  = 3'd5;

  localparam int                  c_WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);

  logic [2:0]           r_state;
  logic [5:0]           r_op;
  logic [c_WAIT_W-1:0]  r_wait;
  logic [CNT_WIDTH-1:0] r_retired;
  logic                 r_run;

  logic [2:0]           w_next;
  logic [c_WAIT_W-1:0]  w_wait_next;
  logic                 w_retire;
  logic                 w_op_load;

  logic w_rtype, w_nori, w_lw, w_sw, w_jr, w_jal, w_bleu, w_legal;

  assign w_rtype = (r_op == 6'b100000) || (r_op == 6'b100110) || (r_op == 6'b000100) ||
                   (r_op == 6'b000000) || (r_op == 6'b000010);
  assign w_nori  = (r_op == 6'b001110);
  assign w_lw    = (r_op == 6'b100011);
  assign w_sw    = (r_op == 6'b101011);
  assign w_jr    = (r_op == 6'b001000);
  assign w_jal   = (r_op == 6'b000011);
  assign w_bleu  = (r_op == 6'b010000);
  assign w_legal = w_rtype | w_nori | w_lw | w_sw | w_jr | w_jal | w_bleu;

  always_comb begin
    w_next      = r_state;
    w_wait_next = r_wait;
    w_retire    = 1'b0;
    w_op_load   = 1'b0;
    case (r_state)
      c_FETCH: begin
        // Nothing is requested until the first edge after reset release.
        if (r_run) begin
          if (bus.mem_ready) begin
            w_next    = c_DECODE;
            w_op_load = 1'b1;
          end else if (r_wait == c_WAIT_LAST) begin
            w_next = c_FAULT;
          end else begin
            w_wait_next = r_wait + c_WAIT_W'(1);
          end
        end
      end
      c_DECODE: w_next = w_legal ? c_EXEC : c_FAULT;
      c_EXEC: begin
        if (w_rtype || w_nori || w_jal) begin
          w_next = c_WB;
        end else if (w_lw || w_sw) begin
          w_next = c_MEM;
        end else begin
          w_next   = c_FETCH;
          w_retire = 1'b1;
        end
      end
      c_MEM: begin
        if (bus.mem_ready) begin
          w_next   = w_lw ? c_WB : c_FETCH;
          w_retire = !w_lw;
        end else if (r_wait == c_WAIT_LAST) begin
          w_next = c_FAULT;
        end else begin
          w_wait_next = r_wait + c_WAIT_W'(1);
        end
      end
      c_WB: begin
        w_next   = c_FETCH;
        w_retire = 1'b1;
      end
      c_FAULT: w_next = c_FAULT;
      default: w_next = c_FAULT;
    endcase
    if (w_next != r_state) begin
      w_wait_next = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= c_FETCH;
      r_op      <= '0;
      r_wait    <= '0;
      r_retired <= '0;
      r_run     <= 1'b0;
    end else begin
      r_run   <= 1'b1;
      r_state <= w_next;
      r_wait  <= w_wait_next;
      if (w_op_load) begin
        r_op <= bus.ins[INS_WIDTH-1 -: 6];
      end
      if (w_retire) begin
        r_retired <= r_retired + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    bus.mem_req        = 1'b0;
    bus.IorD           = 1'b0;
    bus.memWrite       = 1'b0;
    bus.IRWrite        = 1'b0;
    bus.PCWrite        = 1'b0;
    bus.branchEnable   = 1'b0;
    bus.PCSrc          = 2'b00;
    bus.ALUSrcA        = 1'b0;
    bus.ALUSrcB        = 2'b00;
    bus.ALUControl     = '0;
    bus.regDst         = 1'b0;
    bus.regWriteEnable = 1'b0;
    bus.memToReg       = 1'b0;
    if (r_run) begin
      case (r_state)
        c_FETCH: begin
          bus.mem_req = 1'b1;
          bus.ALUSrcB = 2'b01;
          bus.IRWrite = bus.mem_ready;
          bus.PCWrite = bus.mem_ready;
        end
        c_EXEC: begin
          bus.ALUControl = r_op[5 -: ALU_WIDTH];
          bus.ALUSrcA    = 1'b1;
          if (w_nori || w_lw || w_sw) begin
            bus.ALUSrcB = 2'b10;
          end else if (w_bleu) begin
            bus.branchEnable = 1'b1;
            bus.PCSrc        = 2'b10;
          end else if (w_jr) begin
            bus.PCWrite = 1'b1;
            bus.PCSrc   = 2'b11;
          end else if (w_jal) begin
            bus.PCWrite = 1'b1;
            bus.PCSrc   = 2'b01;
            bus.ALUSrcB = 2'b11;
          end
        end
        c_MEM: begin
          bus.mem_req  = 1'b1;
          bus.IorD     = 1'b1;
          bus.memWrite = w_sw;
        end
        c_WB: begin
          bus.regWriteEnable = 1'b1;
          bus.memToReg       = w_lw | w_jal;
          bus.regDst         = w_rtype;
        end
        default: ;
      endcase
    end
  end

  assign bus.state   = r_state;
  assign bus.fault   = (r_state == c_FAULT);
  assign bus.retired = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
//------------------------------------------------------------------------------
// Module  : tb_multicycle_control_fsm
// Brief   : Directed self-checking bench for multicycle_control_fsm.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_control_fsm;

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  multicycle_control_fsm_if #(.INS_WIDTH(32), .ALU_WIDTH(5), .CNT_WIDTH(4)) bus ();

  multicycle_control_fsm #(
    .INS_WIDTH (32),
    .ALU_WIDTH (5),
    .TIMEOUT   (4),
    .CNT_WIDTH (4)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  // Completes a zero-wait fetch; returns in DECODE.
  task automatic fetch(input logic [31:0] i);
    bus.ins       = i;
    bus.mem_ready = 1'b1;
    #1;
    check("fetch_irwrite", bus.IRWrite, 1);
    tick;
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    bus.ins       = '0;
    bus.mem_ready = 1'b0;
    #12;
    check("rst_state",   bus.state,   0);
    check("rst_memreq",  bus.mem_req, 0);
    check("rst_fault",   bus.fault,   0);
    check("rst_retired", bus.retired, 0);
    @(posedge clock); #2;
    reset_n = 1'b1;
    check("rel_idle_memreq", bus.mem_req, 0);
    tick;
    check("rel_memreq", bus.mem_req, 1);

    // and: 4 cycles
    bus.ins = 32'h8000_0000; bus.mem_ready = 1'b1; #1;
    check("and_f_state", bus.state, 0);
    check("and_f_irw",   bus.IRWrite, 1);
    check("and_f_pcw",   bus.PCWrite, 1);
    check("and_f_srcb",  bus.ALUSrcB, 1);
    tick; bus.mem_ready = 1'b0;
    check("and_d_state", bus.state, 1);
    check("and_d_irw",   bus.IRWrite, 0);
    tick;
    check("and_e_state", bus.state, 2);
    check("and_e_alu",   bus.ALUControl, 5'b10000);
    check("and_e_srca",  bus.ALUSrcA, 1);
    check("and_e_srcb",  bus.ALUSrcB, 0);
    tick;
    check("and_w_state", bus.state, 4);
    check("and_w_rwe",   bus.regWriteEnable, 1);
    check("and_w_dst",   bus.regDst, 1);
    check("and_w_m2r",   bus.memToReg, 0);
    tick;
    check("and_state", bus.state, 0);
    check("and_ret",   bus.retired, 1);

    // lw with two data wait states
    fetch(32'h8C00_0000);
    tick;
    check("lw_e_srcb", bus.ALUSrcB, 2);
    tick;
    check("lw_m_state", bus.state, 3);
    check("lw_m_req",   bus.mem_req, 1);
    check("lw_m_iord",  bus.IorD, 1);
    check("lw_m_mw",    bus.memWrite, 0);
    tick;
    check("lw_m2_state", bus.state, 3);
    tick;
    check("lw_m3_state", bus.state, 3);
    bus.mem_ready = 1'b1; #1;
    tick; bus.mem_ready = 1'b0;
    check("lw_w_state", bus.state, 4);
    check("lw_w_m2r",   bus.memToReg, 1);
    check("lw_w_dst",   bus.regDst, 0);
    check("lw_w_rwe",   bus.regWriteEnable, 1);
    tick;
    check("lw_ret", bus.retired, 2);

    // sw
    fetch(32'hAC00_0000);
    tick;
    check("sw_e_mw", bus.memWrite, 0);
    tick;
    bus.mem_ready = 1'b1; #1;
    check("sw_m_state", bus.state, 3);
    check("sw_m_mw",    bus.memWrite, 1);
    check("sw_m_rwe",   bus.regWriteEnable, 0);
    tick; bus.mem_ready = 1'b0;
    check("sw_state", bus.state, 0);
    check("sw_ret",   bus.retired, 3);

    // jr, bleu, jal
    fetch(32'h2000_0000);
    tick;
    check("jr_pcsrc", bus.PCSrc, 3);
    check("jr_pcw",   bus.PCWrite, 1);
    tick;
    check("jr_state", bus.state, 0);
    check("jr_ret",   bus.retired, 4);
    fetch(32'h4000_0000);
    tick;
    check("bleu_pcsrc", bus.PCSrc, 2);
    check("bleu_ben",   bus.branchEnable, 1);
    check("bleu_pcw",   bus.PCWrite, 0);
    tick;
    check("bleu_state", bus.state, 0);
    check("bleu_ret",   bus.retired, 5);
    fetch(32'h0C00_0000);
    tick;
    check("jal_pcsrc", bus.PCSrc, 1);
    check("jal_pcw",   bus.PCWrite, 1);
    check("jal_srcb",  bus.ALUSrcB, 3);
    tick;
    check("jal_w_state", bus.state, 4);
    check("jal_w_m2r",   bus.memToReg, 1);
    check("jal_w_dst",   bus.regDst, 0);
    tick;
    check("jal_ret", bus.retired, 6);

    // Asynchronous reset in the middle of a MEM access
    fetch(32'h8C00_0000);
    tick; tick;
    check("t1_pre_req", bus.mem_req, 1);
    #3; reset_n = 1'b0; #1;
    check("t1_state",   bus.state, 0);
    check("t1_req",     bus.mem_req, 0);
    check("t1_fault",   bus.fault, 0);
    check("t1_retired", bus.retired, 0);
    @(posedge clock); #2;
    reset_n = 1'b1;
    tick;
    check("t1_resume_req", bus.mem_req, 1);

    // 16 retirements wrap the 4-bit counter; first one is nori
    for (int i = 0; i < 16; i++) begin
      fetch((i == 0) ? 32'h3800_0000 : 32'h1000_0000);
      tick;
      check("wrap_srcb", bus.ALUSrcB, (i == 0) ? 2 : 0);
      tick;
      check("wrap_dst", bus.regDst, (i == 0) ? 0 : 1);
      tick;
      check("wrap_ret", bus.retired, (i + 1) % 16);
    end

    // Illegal opcode after one retirement
    fetch(32'h2000_0000);
    tick; tick;
    check("pre_ill_ret", bus.retired, 1);
    fetch(32'hFC00_0000);
    check("ill_d_state", bus.state, 1);
    tick;
    check("ill_state", bus.state, 5);
    check("ill_fault", bus.fault, 1);
    check("ill_req",   bus.mem_req, 0);
    bus.mem_ready = 1'b1;
    tick; tick;
    bus.mem_ready = 1'b0;
    check("ill_hold_state", bus.state, 5);
    check("ill_hold_ret",   bus.retired, 1);
    check("ill_hold_irw",   bus.IRWrite, 0);

    // Fetch timeout with TIMEOUT=4
    reset_n = 1'b0;
    @(posedge clock); #2;
    reset_n = 1'b1;
    tick;
    check("to_req", bus.mem_req, 1);
    tick; tick; tick;
    check("to_3_state", bus.state, 0);
    tick;
    check("to_4_state", bus.state, 5);
    check("to_4_fault", bus.fault, 1);
    tick; tick;
    check("to_hold_state", bus.state, 5);
    reset_n = 1'b0; #1;
    check("to_rst_state", bus.state, 0);
    check("to_rst_fault", bus.fault, 0);
    @(posedge clock); #2;
    reset_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
